// File: rtl/weight_update_pkg.sv
// Shared Q-format constants and FSM encoding for the LMS weight-update engine.
// Default format is Q4.12 with 8 weights.
package weight_update_pkg;

   localparam int Q_WIDTH = 16;
   localparam int Q_FRAC  = 12;
   localparam int VEC_LEN = 8;
   localparam int Q_ONE   = 1 << Q_FRAC;

   localparam logic signed [Q_WIDTH-1:0] WMAX = {1'b0, {(Q_WIDTH-1){1'b1}}};
   localparam logic signed [Q_WIDTH-1:0] WMIN = {1'b1, {(Q_WIDTH-1){1'b0}}};

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SCALE  = 2'd1;
   localparam logic [1:0] ST_UPDATE = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

endpackage

// File: rtl/weight_update_q_mult_sat.sv
// Combinational signed Q-format multiply: full product, arithmetic shift by QP
// (floor), then saturation back to WIDTH bits.
module q_mult_sat
   import weight_update_pkg::*;
#(
   parameter int WIDTH = Q_WIDTH,
   parameter int QP    = Q_FRAC
) (
   input  logic signed [WIDTH-1:0] a,
   input  logic signed [WIDTH-1:0] b,
   output logic signed [WIDTH-1:0] p
);

   localparam logic signed [2*WIDTH-1:0] LIM_HI = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [2*WIDTH-1:0] LIM_LO = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

   logic signed [2*WIDTH-1:0] prod;
   logic signed [2*WIDTH-1:0] shifted;

   assign prod    = a * b;
   assign shifted = prod >>> QP;

   always_comb begin
      p = shifted[WIDTH-1:0];
      if (shifted > LIM_HI) begin
         p = {1'b0, {(WIDTH-1){1'b1}}};
      end else if (shifted < LIM_LO) begin
         p = {1'b1, {(WIDTH-1){1'b0}}};
      end
   end

endmodule

// File: rtl/weight_update.sv
// Sequential LMS weight update: w[i] <= sat(w[i] + sat(mu*err)*x[i]), one element
// per cycle through a single shared Q multiplier.
module weight_update
   import weight_update_pkg::*;
#(
   parameter int WIDTH = Q_WIDTH,
   parameter int QP    = Q_FRAC,
   parameter int LEN   = VEC_LEN
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   clear,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WIDTH-1:0]       mu,
   input  logic [WIDTH-1:0]       err,
   input  logic [LEN*WIDTH-1:0]   x_packed,
   output logic [LEN*WIDTH-1:0]   w_packed,
   output logic                   busy,
   output logic                   done,
   output logic [1:0]             state_dbg
);

   localparam int IW = $clog2(LEN);

   // Handshake: a request transfers on a rising edge where in_valid && in_ready
   // and clear is low; in_ready is high only in IDLE and requests are never queued.

   logic [1:0]                state;
   logic [IW-1:0]             idx;
   logic signed [WIDTH-1:0]   mu_l;
   logic signed [WIDTH-1:0]   err_l;
   logic [LEN*WIDTH-1:0]      x_l;
   logic signed [WIDTH-1:0]   mu_e;
   logic signed [WIDTH-1:0]   w [LEN];

   logic signed [WIDTH-1:0]   mul_a;
   logic signed [WIDTH-1:0]   mul_b;
   logic signed [WIDTH-1:0]   mul_p;
   logic signed [WIDTH-1:0]   w_cur;
   logic signed [WIDTH:0]     sum;
   logic signed [WIDTH-1:0]   w_next;

   // The multiplier forms mu*err in SCALE and mu_e*x[idx] in UPDATE.
   always_comb begin
      mul_a = mu_e;
      mul_b = x_l[idx*WIDTH +: WIDTH];
      if (state == ST_SCALE) begin
         mul_a = mu_l;
         mul_b = err_l;
      end
   end

   q_mult_sat #(.WIDTH(WIDTH), .QP(QP)) u_mult (
      .a (mul_a),
      .b (mul_b),
      .p (mul_p)
   );

   always_comb begin
      w_cur  = w[idx];
      sum    = {w_cur[WIDTH-1], w_cur} + {mul_p[WIDTH-1], mul_p};
      w_next = sum[WIDTH-1:0];
      if (sum[WIDTH] != sum[WIDTH-1]) begin
         w_next = sum[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
         idx   <= '0;
         mu_l  <= '0;
         err_l <= '0;
         x_l   <= '0;
         mu_e  <= '0;
         for (int i = 0; i < LEN; i++) w[i] <= '0;
      end else if (clear) begin
         state <= ST_IDLE;
         idx   <= '0;
         for (int i = 0; i < LEN; i++) w[i] <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  mu_l  <= mu;
                  err_l <= err;
                  x_l   <= x_packed;
                  state <= ST_SCALE;
               end
            end
            ST_SCALE: begin
               mu_e  <= mul_p;
               idx   <= '0;
               state <= ST_UPDATE;
            end
            ST_UPDATE: begin
               w[idx] <= w_next;
               if (idx == IW'(LEN-1)) begin
                  state <= ST_DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      w_packed = '0;
      for (int i = 0; i < LEN; i++) w_packed[i*WIDTH +: WIDTH] = w[i];
   end

   assign in_ready  = (state == ST_IDLE);
   assign busy      = (state == ST_SCALE) || (state == ST_UPDATE);
   assign done      = (state == ST_DONE);
   assign state_dbg = state;

endmodule

// File: doc/weight_update.md
Name: weight_update

Overview:
- Sequential LMS-style weight-update engine for the adaptive filter datapath.
- It is the write-back counterpart of the dot product: the dot product reduces two LEN-vectors to one scalar; this block takes one scalar (the error) and writes back into the LEN-vector of weights.
- Per accepted transaction it computes w[i] <= sat(w[i] + sat(mu*e)*x[i]) for i = 0..LEN-1.
- One shared Q-format multiplier is time-multiplexed across elements, so the block is small and its timing is deterministic.
- The weight vector w_packed feeds the filter's dot-product coefficient input directly.

Parameters:
- WIDTH, 16, signed word width of every operand and weight.
- QP, 12, fractional bits (Q(WIDTH-QP).QP format).
- LEN, 8, vector length (number of weights); must be >= 2.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous clear: zeroes all weights and aborts any operation.
- in_valid  in  1  request: e, mu and x_packed are valid.
- in_ready  out  1  block can accept a request (high only in IDLE).
- mu  in  WIDTH  signed step size, Q format.
- err  in  WIDTH  signed error scalar, Q format.
- x_packed  in  LEN*WIDTH  signed input vector; element i occupies bits [i*WIDTH +: WIDTH].
- w_packed  out  LEN*WIDTH  registered weight vector, same packing as x_packed.
- busy  out  1  high in SCALE and UPDATE.
- done  out  1  one-cycle pulse after the last weight is written.

Behaviour:
- Reset (reset=0, asynchronous):
  - state = IDLE; all weights = 0; index = 0; internal mu_e and latched registers = 0.
  - Outputs: done = 0, busy = 0, in_ready = 1 (the combinational value for IDLE).
- FSM states: IDLE, SCALE, UPDATE, DONE.
  - IDLE: in_ready = 1. When in_valid is high, latch mu, err and x_packed, then go to SCALE. With in_valid low, stay in IDLE.
  - SCALE (1 cycle): mu_e <= qmul(mu_l, err_l). index <= 0. Go to UPDATE.
  - UPDATE (LEN cycles): w[index] <= satadd(w[index], qmul(mu_e, x_l[index])), then index++. After the cycle with index = LEN-1, go to DONE.
  - DONE (1 cycle): done = 1, then go to IDLE.
- Latency:
  - Accept edge at cycle 0. SCALE occupies cycle 1; UPDATE occupies cycles 2..LEN+1.
  - w[i] is visible on w_packed after the edge ending cycle i+2.
  - done is high during cycle LEN+2. The next accept is possible at cycle LEN+3.
- qmul(a,b):
  - Full 2*WIDTH signed product, arithmetically shifted right by QP (truncation toward negative infinity).
  - Result saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- satadd: (WIDTH+1)-bit signed sum, saturated to the same range.
- Inputs are sampled only at the accept edge. Changes to mu, err or x_packed while busy have no effect.
- in_valid while busy: ignored. No queueing; the source must hold in_valid until it sees in_ready.
- clear:
  - Highest priority after reset: all weights = 0, state = IDLE, index = 0, done = 0.
  - If in_valid and clear are high together in IDLE, clear wins and the request is not accepted.
- Weights hold their value between transactions indefinitely.
- Mid-operation reset or clear leaves no partial state. Weights already updated are zeroed as well.

Decomposition:
- Shared package: Q-format constants (QP, WIDTH, Q_ONE = 1<<QP), WMAX/WMIN saturation limits, FSM state encoding.
- One sub-module: q_mult_sat, a combinational signed Q multiply with arithmetic shift and saturation. It is instantiated once in the top block and used for both the mu*e product and the mu_e*x[i] products.
- The add saturation stays inline in weight_update.

Test Plan (WIDTH=16, QP=12, LEN=8; 1.0 = 4096):
1. Reset, then mu=2048, err=4096, all x[i]=4096, in_valid held for 1 cycle -> in_ready drops; done pulses exactly 10 cycles after accept; every w[i]=2048; busy is high for 9 cycles.
2. Repeat scenario 1 twice more -> w[i]=4096, then 6144. Then mu=4096, err=-4096, x[i]=4096 -> w[i]=2048, which checks negative arithmetic and the sign of the shift.
3. Truncation: mu=1, err=-1 -> mu_e=-1 (floor). With x[i]=4096, each w[i] decreases by 1 per transaction.
4. Saturation:
   - Preload via repeated updates to w[i]=30720, then mu=4096, err=4096, x[i]=8192 -> w[i]=32767 (no wrap).
   - Mirror case with err=-4096 -> floor at -32768.
   - mu=32767, err=32767 -> mu_e saturates to 32767.
5. Mixed vector x = {4096,-4096,0,8192,-8192,1,-1,32767}, mu=4096, err=4096, from zero weights -> w = {4096,-4096,0,8192,-8192,1,-1,32767}. During UPDATE, w_packed changes exactly one element per cycle, in index order 0..7.
6. Abort and hazards:
   - Assert clear during UPDATE at index 3 -> all weights 0, state IDLE next cycle, no done pulse.
   - Assert reset (low) mid-UPDATE -> same result, asynchronously.
   - Toggle in_valid and change x while busy -> no effect on the result.
   - Assert in_valid and clear together -> the request is not accepted.
